// File: rtl/cache_access_ctrl.sv
// Single-access sequencer for a set-associative tag store with MESI line states.
// Optional event counters are compiled in when CACHE_STATS_EN is defined.
module cache_access_ctrl #(
  parameter int I_SIZE   = 32,
  parameter int C_SIZE   = 24,
  parameter int D_SIZE   = 6,
  parameter int A_SIZE   = 8,
  parameter int PROTOCOL = 2,
  localparam int WAY_W   = $clog2(A_SIZE),
  localparam int SET_W   = C_SIZE - WAY_W - D_SIZE,
  localparam int TAG_W   = I_SIZE - SET_W - D_SIZE,
  localparam int ENT_W   = PROTOCOL + TAG_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [1:0]                req_op,
  input  logic [I_SIZE-1:0]         req_addr,
  output logic                      resp_valid,
  output logic                      resp_hit,
  output logic [WAY_W-1:0]          resp_way,
  output logic                      tag_rd_en,
  output logic [SET_W-1:0]          tag_rd_set,
  input  logic [A_SIZE*ENT_W-1:0]   tag_rd_data,
  output logic                      tag_wr_en,
  output logic [SET_W-1:0]          tag_wr_set,
  output logic [WAY_W-1:0]          tag_wr_way,
  output logic [ENT_W-1:0]          tag_wr_entry,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic [I_SIZE-1:0]         mem_addr,
  input  logic                      mem_ack
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]               hit_count,
  output logic [31:0]               miss_count,
  output logic [31:0]               wb_count
`endif
);

  // state    | meaning
  // S_IDLE   | req_ready high, waiting for a request
  // S_LOOKUP | tag_rd_en high for the latched set
  // S_COMPARE| tag_rd_data valid; hit/victim decision
  // S_WB     | writing back a modified line
  // S_FILL   | fetching the requested line
  // S_UPDATE | one-cycle tag write
  // S_RESP   | one-cycle resp_valid pulse
  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_COMPARE, S_WB, S_FILL, S_UPDATE, S_RESP
  } state_t;

  localparam logic [PROTOCOL-1:0] ST_I = PROTOCOL'(0);
  localparam logic [PROTOCOL-1:0] ST_E = PROTOCOL'(2);
  localparam logic [PROTOCOL-1:0] ST_M = PROTOCOL'(3);
  localparam logic [1:0] OP_WR  = 2'b01;
  localparam logic [1:0] OP_INV = 2'b10;

  state_t              state;
  logic [1:0]          op_q;
  logic [TAG_W-1:0]    tag_q;
  logic [SET_W-1:0]    set_q;
  logic [WAY_W-1:0]    way_q;
  logic                hit_q;
  logic [PROTOCOL-1:0] new_st_q;
  logic [WAY_W-1:0]    rr_ptr;

  logic [PROTOCOL-1:0] way_st [A_SIZE];
  logic [TAG_W-1:0]    way_tg [A_SIZE];
  logic                hit_any;
  logic [WAY_W-1:0]    hit_way;
  logic                inv_any;
  logic [WAY_W-1:0]    inv_way;
  logic [WAY_W-1:0]    victim_way;
  logic [PROTOCOL-1:0] hit_st;
  logic [PROTOCOL-1:0] victim_st;
  logic [TAG_W-1:0]    victim_tg;
  logic                is_wr;
  logic                is_inv;

  // The byte offset never affects tag state or the line-aligned memory address.
  logic unused_offset;
  assign unused_offset = ^req_addr[D_SIZE-1:0];

  assign is_wr  = (op_q == OP_WR);
  assign is_inv = (op_q == OP_INV);

  always_comb begin
    for (int i = 0; i < A_SIZE; i++) begin
      way_st[i] = tag_rd_data[i*ENT_W + TAG_W +: PROTOCOL];
      way_tg[i] = tag_rd_data[i*ENT_W +: TAG_W];
    end
  end

  // Scan from the top so the lowest matching / invalid way wins.
  always_comb begin
    hit_any = 1'b0;
    hit_way = '0;
    inv_any = 1'b0;
    inv_way = '0;
    for (int i = A_SIZE - 1; i >= 0; i--) begin
      if (way_st[i] != ST_I && way_tg[i] == tag_q) begin
        hit_any = 1'b1;
        hit_way = WAY_W'(i);
      end
      if (way_st[i] == ST_I) begin
        inv_any = 1'b1;
        inv_way = WAY_W'(i);
      end
    end
    victim_way = inv_any ? inv_way : rr_ptr;
    hit_st     = way_st[hit_way];
    victim_st  = way_st[victim_way];
    victim_tg  = way_tg[victim_way];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      req_ready    <= 1'b0;
      resp_valid   <= 1'b0;
      resp_hit     <= 1'b0;
      resp_way     <= '0;
      tag_rd_en    <= 1'b0;
      tag_rd_set   <= '0;
      tag_wr_en    <= 1'b0;
      tag_wr_set   <= '0;
      tag_wr_way   <= '0;
      tag_wr_entry <= '0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      op_q         <= '0;
      tag_q        <= '0;
      set_q        <= '0;
      way_q        <= '0;
      hit_q        <= 1'b0;
      new_st_q     <= ST_I;
      rr_ptr       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            op_q       <= req_op;
            tag_q      <= req_addr[I_SIZE-1 -: TAG_W];
            set_q      <= req_addr[D_SIZE +: SET_W];
            tag_rd_set <= req_addr[D_SIZE +: SET_W];
            tag_rd_en  <= 1'b1;
            req_ready  <= 1'b0;
            state      <= S_LOOKUP;
          end
        end

        S_LOOKUP: begin
          tag_rd_en <= 1'b0;
          state     <= S_COMPARE;
        end

        S_COMPARE: begin
          if (is_inv) begin
            if (hit_any) begin
              hit_q    <= 1'b1;
              way_q    <= hit_way;
              new_st_q <= ST_I;
              if (hit_st == ST_M) begin
                mem_req  <= 1'b1;
                mem_we   <= 1'b1;
                mem_addr <= {tag_q, set_q, {D_SIZE{1'b0}}};
                state    <= S_WB;
              end else begin
                tag_wr_en    <= 1'b1;
                tag_wr_set   <= set_q;
                tag_wr_way   <= hit_way;
                tag_wr_entry <= {ST_I, tag_q};
                state        <= S_UPDATE;
              end
            end else begin
              resp_valid <= 1'b1;
              resp_hit   <= 1'b0;
              resp_way   <= '0;
              state      <= S_RESP;
            end
          end else if (hit_any) begin
            if (is_wr && hit_st != ST_M) begin
              hit_q        <= 1'b1;
              way_q        <= hit_way;
              tag_wr_en    <= 1'b1;
              tag_wr_set   <= set_q;
              tag_wr_way   <= hit_way;
              tag_wr_entry <= {ST_M, tag_q};
              state        <= S_UPDATE;
            end else begin
              resp_valid <= 1'b1;
              resp_hit   <= 1'b1;
              resp_way   <= hit_way;
              state      <= S_RESP;
            end
          end else begin
            hit_q    <= 1'b0;
            way_q    <= victim_way;
            new_st_q <= is_wr ? ST_M : ST_E;
            if (!inv_any)
              rr_ptr <= rr_ptr + 1'b1;
            mem_req <= 1'b1;
            if (victim_st == ST_M) begin
              mem_we   <= 1'b1;
              mem_addr <= {victim_tg, set_q, {D_SIZE{1'b0}}};
              state    <= S_WB;
            end else begin
              mem_we   <= 1'b0;
              mem_addr <= {tag_q, set_q, {D_SIZE{1'b0}}};
              state    <= S_FILL;
            end
          end
        end

        S_WB: begin
          if (mem_ack) begin
            mem_we <= 1'b0;
            if (is_inv) begin
              mem_req      <= 1'b0;
              tag_wr_en    <= 1'b1;
              tag_wr_set   <= set_q;
              tag_wr_way   <= way_q;
              tag_wr_entry <= {new_st_q, tag_q};
              state        <= S_UPDATE;
            end else begin
              // mem_req stays high; the fill request follows directly.
              mem_addr <= {tag_q, set_q, {D_SIZE{1'b0}}};
              state    <= S_FILL;
            end
          end
        end

        S_FILL: begin
          if (mem_ack) begin
            mem_req      <= 1'b0;
            tag_wr_en    <= 1'b1;
            tag_wr_set   <= set_q;
            tag_wr_way   <= way_q;
            tag_wr_entry <= {new_st_q, tag_q};
            state        <= S_UPDATE;
          end
        end

        S_UPDATE: begin
          tag_wr_en  <= 1'b0;
          resp_valid <= 1'b1;
          resp_hit   <= hit_q;
          resp_way   <= way_q;
          state      <= S_RESP;
        end

        S_RESP: begin
          resp_valid <= 1'b0;
          req_ready  <= 1'b1;
          state      <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef CACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_count  <= '0;
      miss_count <= '0;
      wb_count   <= '0;
    end else begin
      if (state == S_RESP) begin
        if (resp_hit) begin
          if (hit_count != '1) hit_count <= hit_count + 1'b1;
        end else begin
          if (miss_count != '1) miss_count <= miss_count + 1'b1;
        end
      end
      if (state == S_WB && mem_ack && wb_count != '1)
        wb_count <= wb_count + 1'b1;
    end
  end
`endif

endmodule
